// File: rtl/flow_framer.sv
// flow_framer: turns a raw pixel stream (valid + start-of-frame marker) into
// a framed fv/dv/data flow of programmed width x height. Frame geometry is
// latched when a frame is accepted. fv is held through the last pixel plus a
// short tail. A start-of-frame marker seen mid-frame aborts the frame and
// raises err_o.
module flow_framer #(
   parameter int DATA_SIZE = 16,
   parameter int DIM_BITS  = 16,
   parameter int FV_TAIL   = 4
) (
   input  logic                 clk_proc,
   input  logic                 reset,
   input  logic                 enable_i,
   input  logic [DIM_BITS-1:0]  width_i,
   input  logic [DIM_BITS-1:0]  height_i,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic                 out_fv,
   output logic                 out_dv,
   output logic [DATA_SIZE-1:0] out_data,
   output logic [15:0]          frame_cnt_o,
   output logic                 err_o
);

   localparam int TW = (FV_TAIL < 2) ? 1 : $clog2(FV_TAIL + 1);
   localparam logic [DIM_BITS-1:0] DIM_ONE   = DIM_BITS'(1);
   localparam logic [TW-1:0]       TAIL_LOAD = TW'(FV_TAIL);
   localparam logic [TW-1:0]       TAIL_ONE  = TW'(1);

   typedef enum logic [2:0] {IDLE, WAIT_SOF, ACTIVE, TAIL, GAP} state_t;

   state_t              state;
   logic [DIM_BITS-1:0] w_q, h_q, x_q, y_q;
   logic [TW-1:0]       tail_q;

   logic [DIM_BITS-1:0] cur_w, cur_h, cur_x, cur_y, nx, ny;
   logic                x_end, last_px, dims_ok;

   // Position of the pixel being accepted this cycle. The sof pixel sits at
   // (0,0) of the geometry presented on the inputs, since it is not latched yet.
   always_comb begin
      cur_w   = w_q;
      cur_h   = h_q;
      cur_x   = x_q;
      cur_y   = y_q;
      if (state == WAIT_SOF) begin
         cur_w = width_i;
         cur_h = height_i;
         cur_x = '0;
         cur_y = '0;
      end
      x_end   = (cur_x == cur_w - DIM_ONE);
      last_px = x_end && (cur_y == cur_h - DIM_ONE);
      nx      = x_end ? '0 : cur_x + DIM_ONE;
      ny      = x_end ? cur_y + DIM_ONE : cur_y;
      dims_ok = (width_i != '0) && (height_i != '0);
   end

   // Framing FSM with registered outputs. dv and err are single-cycle
   // strobes, so they default low on every edge.
   always_ff @(posedge clk_proc or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         w_q         <= '0;
         h_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         tail_q      <= '0;
         out_fv      <= 1'b0;
         out_dv      <= 1'b0;
         out_data    <= '0;
         frame_cnt_o <= '0;
         err_o       <= 1'b0;
      end else begin
         out_dv <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: begin
               out_fv <= 1'b0;
               if (enable_i) state <= WAIT_SOF;
            end

            WAIT_SOF: begin
               if (!enable_i) begin
                  state <= IDLE;
               end else if (in_valid && in_sof && dims_ok) begin
                  w_q      <= width_i;
                  h_q      <= height_i;
                  x_q      <= nx;
                  y_q      <= ny;
                  out_fv   <= 1'b1;
                  out_dv   <= 1'b1;
                  out_data <= in_data;
                  if (last_px) begin
                     tail_q <= TAIL_LOAD;
                     state  <= TAIL;
                  end else begin
                     state  <= ACTIVE;
                  end
               end
            end

            ACTIVE: begin
               if (in_valid && in_sof) begin
                  // Resync: abandon the frame without counting it.
                  err_o  <= 1'b1;
                  out_fv <= 1'b0;
                  state  <= GAP;
               end else if (in_valid) begin
                  x_q      <= nx;
                  y_q      <= ny;
                  out_dv   <= 1'b1;
                  out_data <= in_data;
                  if (last_px) begin
                     tail_q <= TAIL_LOAD;
                     state  <= TAIL;
                  end
               end
            end

            TAIL: begin
               // fv stays high for FV_TAIL cycles after the last pixel cycle.
               if (tail_q == '0) begin
                  out_fv      <= 1'b0;
                  frame_cnt_o <= frame_cnt_o + 16'd1;
                  state       <= enable_i ? WAIT_SOF : IDLE;
               end else begin
                  tail_q <= tail_q - TAIL_ONE;
               end
            end

            GAP: begin
               out_fv <= 1'b0;
               state  <= WAIT_SOF;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
